// File: rtl/hazard_forward_unit_pkg.sv
// Shared core definitions for the hazard/forwarding unit:
// forward-select encodings, register index width, shadow stage types.
package hazard_forward_unit_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } dest_t;

    localparam dest_t DEST_NONE = '0;

    // A stage only produces a forwardable value when it writes a real register
    function automatic logic dest_live(input dest_t d);
        return d.reg_write && (d.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_sel_calc.sv
// Operand forward-select function: picks the youngest live
// producer of a source register, never x0.
module fwd_sel_calc
    import hazard_forward_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    output logic [1:0]       sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = rs_used && ex_reg_write
                  && (ex_rd != '0) && (rs == ex_rd);
    assign mem_hit = rs_used && mem_reg_write
                  && (mem_rd != '0) && (rs == mem_rd);

    // Younger producer (EX, which becomes MEM) wins over the older one
    always_comb begin
        sel = FWD_RF;
        priority case (1'b1)
            ex_hit:  sel = FWD_MEM;
            mem_hit: sel = FWD_WB;
            default: sel = FWD_RF;
        endcase
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control with a shadow pipeline.
// Define HFU_PERF_CNT_EN to add stall/flush performance counters.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_valid,
    input  logic       ex_branch_taken,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       flush_ex
`ifdef HFU_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    dest_t ex_q;
    logic  ex_mem_read;
    dest_t mem_q;
    dest_t wb_q;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       rs1_on_ex;
    logic       rs2_on_ex;
    logic       load_use;
    logic       redirect;
    logic       stall;
    logic       bubble;

    // WB is tracked for completeness; the register file is write-through
    logic unused_wb;
    assign unused_wb = ^wb_q;

    fwd_sel_calc u_sel_a (
        .rs            (id_rs1),
        .rs_used       (id_rs1_used),
        .ex_rd         (ex_q.rd),
        .ex_reg_write  (ex_q.reg_write),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .sel           (sel_a)
    );

    fwd_sel_calc u_sel_b (
        .rs            (id_rs2),
        .rs_used       (id_rs2_used),
        .ex_rd         (ex_q.rd),
        .ex_reg_write  (ex_q.reg_write),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .sel           (sel_b)
    );

    assign rs1_on_ex = id_rs1_used && (id_rs1 == ex_q.rd);
    assign rs2_on_ex = id_rs2_used && (id_rs2 == ex_q.rd);

    assign load_use = id_valid && ex_mem_read
                   && dest_live(ex_q)
                   && (rs1_on_ex || rs2_on_ex);

    // Gated by reset so a redirect seen during reset flushes nothing
    assign redirect = ex_branch_taken && rst_n;
    assign stall    = load_use && !redirect;
    assign bubble   = !id_valid || load_use || redirect;

    assign stall_if = stall;
    assign stall_id = stall;
    assign flush_id = redirect;
    assign flush_ex = redirect || load_use;

    // Advance shadow stages; register selects as ID enters EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= DEST_NONE;
            ex_mem_read <= 1'b0;
            mem_q       <= DEST_NONE;
            wb_q        <= DEST_NONE;
            fwd_a_sel   <= FWD_RF;
            fwd_b_sel   <= FWD_RF;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble) begin
                ex_q        <= DEST_NONE;
                ex_mem_read <= 1'b0;
                fwd_a_sel   <= FWD_RF;
                fwd_b_sel   <= FWD_RF;
            end else begin
                ex_q.rd        <= id_rd;
                ex_q.reg_write <= id_reg_write;
                ex_mem_read    <= id_mem_read;
                fwd_a_sel      <= sel_a;
                fwd_b_sel      <= sel_b;
            end
        end
    end

`ifdef HFU_PERF_CNT_EN
    // Saturating event counters; a flush cycle is a redirect cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
            if (redirect && (flush_count != '1))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
